display_pic_window: RTL and testbench

//   Pixel-source stage between the VGA timing controller and the image RAM.

---
 rtl/display_pic_window.sv | 105 ++++++++++
 tb/tb_display_pic_window.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_pic_window.sv
// Pixel-source stage: maps the VGA scan position into a movable, integer-scaled,
// horizontally scrolling image window, addresses the image RAM and expands words to RGB888.
`timescale 1ns/1ps
module display_pic_window #(
  parameter int          CW          = 4,
  parameter int          IMG_XW      = 9,
  parameter int          IMG_YW      = 9,
  parameter int          SCALE_SH    = 0,
  parameter int          MEM_LAT     = 1,
  parameter int          SCROLL_STEP = 1,
  parameter logic [23:0] BG_COLOR    = 24'h0
) (
  input  logic                       clk_div,
  input  logic                       rst,
  input  logic [9:0]                 h_addr,
  input  logic [9:0]                 v_addr,
  input  logic [9:0]                 pos_x,
  input  logic [9:0]                 pos_y,
  input  logic                       scroll_en,
  output logic [IMG_XW+IMG_YW-1:0]   mem_addr,
  input  logic [3*CW-1:0]            mem_data,
  output logic [23:0]                data
);

  localparam logic [15:0] WIN_W = 16'(2 ** (IMG_XW + SCALE_SH));
  localparam logic [15:0] WIN_H = 16'(2 ** (IMG_YW + SCALE_SH));

  typedef struct packed {
    logic [9:0]        px;
    logic [9:0]        py;
    logic [IMG_XW-1:0] scroll_x;
  } frame_t;

  frame_t            frame_q;
  frame_t            cur;
  logic              origin_q;
  logic              frame_start;
  logic              in_win;
  logic [15:0]       h_ext, v_ext, px_ext, py_ext;
  logic [IMG_XW-1:0] img_x;
  logic [IMG_YW-1:0] img_y;
  logic [MEM_LAT:0]  flag_pipe;

  // Bit-replicating expansion of one CW-bit channel to 8 bits (MSB-aligned).
  function automatic logic [7:0] expand_ch(input logic [CW-1:0] ch);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[7-i] = ch[CW-1-(i % CW)];
    return r;
  endfunction

  function automatic logic [23:0] expand(input logic [3*CW-1:0] w);
    return {expand_ch(w[3*CW-1:2*CW]), expand_ch(w[2*CW-1:CW]), expand_ch(w[CW-1:0])};
  endfunction

  assign frame_start = (h_addr == '0) && (v_addr == '0) && !origin_q;

  // A frame-start pixel already sees the freshly latched position and scroll.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    cur = frame_q;
    if (frame_start) begin
      cur.px = pos_x;
      cur.py = pos_y;
      if (scroll_en) cur.scroll_x = frame_q.scroll_x + IMG_XW'(SCROLL_STEP);
    end
  end

  assign h_ext  = 16'(h_addr);
  assign v_ext  = 16'(v_addr);
  assign px_ext = 16'(cur.px);
  assign py_ext = 16'(cur.py);

  // Wide compare so a window running past column 1023 never wraps back in.
  assign in_win = (h_ext >= px_ext) && (h_ext < px_ext + WIN_W) &&
                  (v_ext >= py_ext) && (v_ext < py_ext + WIN_H);

  assign img_x = IMG_XW'((h_ext - px_ext) >> SCALE_SH) + cur.scroll_x;
  assign img_y = IMG_YW'((v_ext - py_ext) >> SCALE_SH);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      origin_q <= 1'b0;
      frame_q  <= '0;
    end else begin
      origin_q <= (h_addr == '0) && (v_addr == '0);
      if (frame_start) frame_q <= cur;
    end
  end

  // mem_addr holds outside the window; the delayed flag masks the stale read data.
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      mem_addr  <= '0;
      flag_pipe <= '0;
      data      <= '0;
    end else begin
      if (in_win) mem_addr <= {img_x, img_y};
      flag_pipe <= {flag_pipe[MEM_LAT-1:0], in_win};
      data      <= flag_pipe[MEM_LAT] ? expand(mem_data) : BG_COLOR;
    end
  end

endmodule

// File: tb/tb_display_pic_window.sv
// Scoreboard bench for display_pic_window: two builds (MEM_LAT=1/SCALE_SH=0 and
// MEM_LAT=2/SCALE_SH=1) share stimulus; an arithmetic window model predicts every output.
`timescale 1ns/1ps
module tb_display_pic_window;

  localparam int          XW = 9, YW = 9, AW = 18, CW = 4;
  localparam int          S_A = 0, LAT_A = 1, STEP_A = 1;
  localparam int          S_B = 1, LAT_B = 2, STEP_B = 3;
  localparam logic [23:0] BG_A = 24'h000000;
  localparam logic [23:0] BG_B = 24'h123456;

  logic          clk_div = 1'b0;
  logic          rst = 1'b1;
  logic [9:0]    h_addr = '0, v_addr = '0, pos_x = '0, pos_y = '0;
  logic          scroll_en = 1'b0;
  logic [AW-1:0] mem_addr_a, mem_addr_b;
  logic [11:0]   mem_data_a, mem_data_b;
  logic [11:0]   rd_a, rd_b0, rd_b1;
  logic [23:0]   data_a, data_b;

  int checks = 0;
  int errors = 0;

  logic          stim_v = 1'b0;
  logic [3:0]    vp;
  logic [23:0]   qd_a[$], qd_b[$];
  logic [AW-1:0] qa_a[$], qa_b[$];

  int  m_px[2], m_py[2], m_scroll[2], m_last[2];
  bit  m_origin;
  logic [9:0] cur_px = '0, cur_py = '0;
  bit  cur_en = 1'b0;

  always #5 clk_div = ~clk_div;

  display_pic_window #(.CW(CW), .IMG_XW(XW), .IMG_YW(YW), .SCALE_SH(S_A), .MEM_LAT(LAT_A),
                       .SCROLL_STEP(STEP_A), .BG_COLOR(BG_A)) dut_a (
    .clk_div(clk_div), .rst(rst), .h_addr(h_addr), .v_addr(v_addr), .pos_x(pos_x),
    .pos_y(pos_y), .scroll_en(scroll_en), .mem_addr(mem_addr_a), .mem_data(mem_data_a),
    .data(data_a));

  display_pic_window #(.CW(CW), .IMG_XW(XW), .IMG_YW(YW), .SCALE_SH(S_B), .MEM_LAT(LAT_B),
                       .SCROLL_STEP(STEP_B), .BG_COLOR(BG_B)) dut_b (
    .clk_div(clk_div), .rst(rst), .h_addr(h_addr), .v_addr(v_addr), .pos_x(pos_x),
    .pos_y(pos_y), .scroll_en(scroll_en), .mem_addr(mem_addr_b), .mem_data(mem_data_b),
    .data(data_b));

  // Image contents: fixed word at address 0, hashed pattern elsewhere.
  function automatic logic [11:0] ram_word(input int inst, input logic [AW-1:0] addr);
    logic [31:0] hsh;
    if (addr == '0) return 12'hF80;
    hsh = 32'(addr) * 32'h9E3779B1 + 32'(inst) * 32'h7F4A7C15;
    return hsh[27:16];
  endfunction

  // Synchronous RAM models with one and two cycles of read latency.
  always @(posedge clk_div) begin
    rd_a  <= ram_word(0, mem_addr_a);
    rd_b0 <= ram_word(1, mem_addr_b);
    rd_b1 <= rd_b0;
  end
  assign mem_data_a = rd_a;
  assign mem_data_b = rd_b1;

  // Expansion by concatenating copies of the channel and keeping the top 8 bits.
  function automatic logic [23:0] expand_model(input logic [11:0] w);
    logic [23:0] r;
    int ch, rep, n;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      ch  = (int'(w) >> (CW * (2 - c))) & ((1 << CW) - 1);
      rep = 0;
      n   = 0;
      while (n < 8 + CW) begin
        rep = (rep << CW) | ch;
        n   = n + CW;
      end
      r[8*(2-c) +: 8] = 8'(rep >> (n - 8));
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_origin = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_px[i] = 0; m_py[i] = 0; m_scroll[i] = 0; m_last[i] = 0;
    end
  endtask

  // Reference model for the pixel currently presented on the inputs.
  task automatic model_step();
    bit at0, fs;
    at0 = (h_addr == 0) && (v_addr == 0);
    fs  = at0 && !m_origin;
    m_origin = at0;
    for (int i = 0; i < 2; i++) begin
      int sh, stp, w, hgt, h, v, ix, iy;
      bit inw;
      logic [23:0] exp;
      sh  = (i == 0) ? S_A : S_B;
      stp = (i == 0) ? STEP_A : STEP_B;
      h   = int'(h_addr);
      v   = int'(v_addr);
      if (fs) begin
        m_px[i] = int'(pos_x);
        m_py[i] = int'(pos_y);
        if (scroll_en) m_scroll[i] = (m_scroll[i] + stp) % (1 << XW);
      end
      w   = (1 << XW) << sh;
      hgt = (1 << YW) << sh;
      inw = (h >= m_px[i]) && (h < m_px[i] + w) && (v >= m_py[i]) && (v < m_py[i] + hgt);
      if (inw) begin
        ix = (((h - m_px[i]) >> sh) + m_scroll[i]) % (1 << XW);
        iy = (v - m_py[i]) >> sh;
        m_last[i] = ix * (1 << YW) + iy;
        exp = expand_model(ram_word(i, AW'(m_last[i])));
      end else begin
        exp = (i == 0) ? BG_A : BG_B;
      end
      if (i == 0) begin
        qa_a.push_back(AW'(m_last[0]));
        qd_a.push_back(exp);
      end else begin
        qa_b.push_back(AW'(m_last[1]));
        qd_b.push_back(exp);
      end
    end
  endtask

  task automatic apply(input logic [9:0] h, input logic [9:0] v, input logic [9:0] px,
                       input logic [9:0] py, input bit en);
    h_addr = h; v_addr = v; pos_x = px; pos_y = py; scroll_en = en;
    stim_v = 1'b1;
    model_step();
  endtask

  task automatic step(input logic [9:0] h, input logic [9:0] v, input logic [9:0] px,
                      input logic [9:0] py, input bit en);
    @(negedge clk_div);
    apply(h, v, px, py, en);
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic do_reset(input int n);
    @(negedge clk_div);
    rst = 1'b1;
    stim_v = 1'b0;
    qa_a.delete(); qa_b.delete(); qd_a.delete(); qd_b.delete();
    model_reset();
    #1;
    check("rst_data_a", 32'(data_a), 32'(0));
    check("rst_data_b", 32'(data_b), 32'(0));
    check("rst_addr_a", 32'(mem_addr_a), 32'(0));
    check("rst_addr_b", 32'(mem_addr_b), 32'(0));
    repeat (n) @(negedge clk_div);
    rst = 1'b0;
    apply(h_addr, v_addr, pos_x, pos_y, scroll_en);
  endtask

  // Tracks which sampled cycles carry a modelled pixel through each pipeline depth.
  always @(posedge clk_div or posedge rst) begin
    if (rst) vp <= '0;
    else     vp <= {vp[2:0], stim_v};
  end

  // Monitor: pops the expected response whenever an output is due.
  always @(negedge clk_div) begin
    if (!rst) begin
      if (vp[0]) begin
        if (qa_a.size() == 0 || qa_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL addr_queue: got empty expected entry at %0t", $time);
        end else begin
          check("mem_addr_a", 32'(mem_addr_a), 32'(qa_a.pop_front()));
          check("mem_addr_b", 32'(mem_addr_b), 32'(qa_b.pop_front()));
        end
      end
      if (vp[LAT_A+1]) begin
        if (qd_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL data_a_queue: got empty expected entry at %0t", $time);
        end else check("data_a", 32'(data_a), 32'(qd_a.pop_front()));
      end
      if (vp[LAT_B+1]) begin
        if (qd_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL data_b_queue: got empty expected entry at %0t", $time);
        end else check("data_b", 32'(data_b), 32'(qd_b.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $fatal(1, "time limit");
  end

  initial begin
    model_reset();
    do_reset(2);
    // Origin pixel held: data appears 3 (build A) and 4 (build B) edges later.
    repeat (3) step(10'd0, 10'd0, 10'd0, 10'd0, 1'b0);
    check("t1_data_a", 32'(data_a), 32'h00FF8800);
    check("t1_addr_a", 32'(mem_addr_a), 32'(0));
    step(10'd0, 10'd0, 10'd0, 10'd0, 1'b0);
    check("t6_data_b", 32'(data_b), 32'h00FF8800);

    // Window at (100,50): left edge, scaling, right side of the screen, mid-frame move.
    step(10'd5,    10'd5,   10'd100, 10'd50, 1'b0);
    step(10'd0,    10'd0,   10'd100, 10'd50, 1'b0);
    step(10'd99,   10'd50,  10'd100, 10'd50, 1'b0);
    step(10'd100,  10'd50,  10'd100, 10'd50, 1'b0);
    step(10'd102,  10'd50,  10'd100, 10'd50, 1'b0);
    step(10'd1023, 10'd50,  10'd100, 10'd50, 1'b0);
    step(10'd100,  10'd49,  10'd100, 10'd50, 1'b0);
    step(10'd101,  10'd561, 10'd100, 10'd50, 1'b0);
    step(10'd101,  10'd562, 10'd100, 10'd50, 1'b0);
    step(10'd300,  10'd60,  10'd200, 10'd80, 1'b0);
    step(10'd150,  10'd60,  10'd200, 10'd80, 1'b0);
    step(10'd0,    10'd0,   10'd200, 10'd80, 1'b0);
    step(10'd150,  10'd90,  10'd200, 10'd80, 1'b0);
    step(10'd199,  10'd80,  10'd200, 10'd80, 1'b0);
    step(10'd200,  10'd80,  10'd200, 10'd80, 1'b0);

    // Scrolling across more than a full wrap of the image width.
    for (int f = 0; f < 520; f++) begin
      step(10'd0,   10'd0,   10'd10, 10'd20, 1'b1);
      step(10'd10,  10'd20,  10'd10, 10'd20, 1'b1);
      step(10'd11,  10'd21,  10'd10, 10'd20, 1'b1);
      step(10'd700, 10'd700, 10'd10, 10'd20, 1'b1);
    end

    // Origin held for several cycles counts as one frame start.
    step(10'd5, 10'd5, 10'd0, 10'd0, 1'b1);
    repeat (4) step(10'd0, 10'd0, 10'd0, 10'd0, 1'b1);
    step(10'd0, 10'd1, 10'd0, 10'd0, 1'b1);

    // Randomised scan positions biased towards window edges and frame starts.
    for (int i = 0; i < 3000; i++) begin
      int r, k, wk, off;
      logic [9:0] h, v;
      if (i == 1500) do_reset(1);
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 19) == 0) begin
        cur_px = 10'($urandom_range(0, 700));
        cur_py = 10'($urandom_range(0, 700));
      end
      if ($urandom_range(0, 9) == 0) cur_en = !cur_en;
      if (r < 8) begin
        h = '0; v = '0;
      end else if (r < 45) begin
        k  = $urandom_range(0, 1);
        wk = 512 << ((k == 0) ? S_A : S_B);
        case ($urandom_range(0, 4))
          0: off = -1;
          1: off = 0;
          2: off = 1;
          3: off = wk - 1;
          default: off = wk;
        endcase
        h = 10'(m_px[k] + off);
        v = 10'(m_py[k] + $urandom_range(0, 40));
      end else begin
        h = 10'($urandom_range(0, 1023));
        v = 10'($urandom_range(0, 1023));
      end
      step(h, v, cur_px, cur_py, cur_en);
    end

    @(negedge clk_div);
    stim_v = 1'b0;
    repeat (6) @(negedge clk_div);
    check("drain_a", 32'(qd_a.size() + qa_a.size()), 32'(0));
    check("drain_b", 32'(qd_b.size() + qa_b.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
